alu_pipe_simd: RTL and testbench

Parametrised, pipelined successor to the 16-bit combinational execute-stage ALU.
- Width and SIMD lane count are generic; lane-wise saturating add and subtract are supported.
- Two register stages with valid/ready handshake; flags are held in proper registers rather than combinational self-hold.
- Sits in the EX stage between operand forwarding and the EX/MEM latch; the result stalls upstream on backpressure.

---
 rtl/alu_pipe_pkg.sv | 36 +++
 rtl/simd_lane_addsub.sv | 36 +++
 rtl/alu_pipe_simd.sv | 192 +++++++++++++++++++
 tb/tb_alu_pipe_simd.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared opcode encoding and saturation helper for the pipelined SIMD ALU.
// Opcode 7 is ADDC when ALU_CARRY_FLAG_EN is defined, reserved otherwise.
package alu_pipe_pkg;

    localparam int OP_W      = 3;
    localparam int SAT_MAX_L = 64;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_ADD   = 3'd0;
    localparam op_t OP_SUB   = 3'd1;
    localparam op_t OP_PADDS = 3'd2;
    localparam op_t OP_PSUBS = 3'd3;
    localparam op_t OP_NAND  = 3'd4;
    localparam op_t OP_XOR   = 3'd5;
    localparam op_t OP_PASSB = 3'd6;
    localparam op_t OP_RSVD  = 3'd7;
    localparam op_t OP_ADDC  = 3'd7;

    // Lane clamp value in the low l bits: 0111..1 (neg=0) or 1000..0 (neg=1).
    function automatic logic [SAT_MAX_L-1:0] lane_sat_pattern(input int l, input logic neg);
        logic [SAT_MAX_L-1:0] pat;
        pat = {SAT_MAX_L{1'b0}};
        for (int i = 0; i < SAT_MAX_L; i++) begin
            if (i < l - 1) begin
                pat[i] = ~neg;
            end else if (i == l - 1) begin
                pat[i] = neg;
            end else begin
                pat[i] = 1'b0;
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/simd_lane_addsub.sv
// One L-bit adder/subtractor lane (a + b or a + ~b + 1) with optional signed
// saturation. Used per SIMD lane and, with L = WIDTH, for full-width ADD/SUB.
module simd_lane_addsub
    import alu_pipe_pkg::*;
#(
    parameter int L = 8
) (
    input  logic [L-1:0] a,
    input  logic [L-1:0] b,
    input  logic         sub,
    input  logic         sat,
    output logic [L-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    logic [L-1:0] w_bx;
    logic [L:0]   w_full;
    logic [L-1:0] w_raw;

    assign w_bx   = sub ? ~b : b;
    assign w_full = {1'b0, a} + {1'b0, w_bx} + {{L{1'b0}}, sub};
    assign w_raw  = w_full[L-1:0];
    assign cout   = w_full[L];
    assign ovf    = (a[L-1] == w_bx[L-1]) && (w_raw[L-1] != a[L-1]);

    // Overflow direction follows the common operand sign.
    always_comb begin
        if (sat && ovf) begin
            sum = L'(lane_sat_pattern(L, a[L-1]));
        end else begin
            sum = w_raw;
        end
    end

endmodule

// File: rtl/alu_pipe_simd.sv
// Two-stage valid/ready EX-stage ALU with lane-wise saturating SIMD add/sub.
// Define ALU_CARRY_FLAG_EN to add the cf output and opcode 7 = ADDC.
module alu_pipe_simd
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             nf,
`ifdef ALU_CARRY_FLAG_EN
    output logic             cf,
`endif
    output logic             vf
);

    localparam int LW = WIDTH / LANES;

    logic             r_s1_valid;
    op_t              r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s2_valid;
    logic             r_s2_fl;
    logic             r_s2_vf;
    logic [WIDTH-1:0] r_result;
    logic             r_zf;
    logic             r_nf;
    logic             r_vf;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [WIDTH-1:0] w_full_sum;
    logic             w_full_cout;
    logic             w_full_ovf;
    logic [WIDTH-1:0] w_lane_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_fl;
    logic             w_vf;

    assign w_s2_adv  = ~r_s2_valid | out_ready;
    assign w_s1_adv  = r_s1_valid & w_s2_adv;
    assign in_ready  = ~rst & (~r_s1_valid | w_s2_adv);
    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign zf        = r_zf;
    assign nf        = r_nf;
    assign vf        = r_vf;

    simd_lane_addsub #(.L(WIDTH)) u_full (
        .a    (r_s1_a),
        .b    (r_s1_b),
        .sub  (r_s1_op == OP_SUB),
        .sat  (1'b0),
        .sum  (w_full_sum),
        .cout (w_full_cout),
        .ovf  (w_full_ovf)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        simd_lane_addsub #(.L(LW)) u_lane (
            .a    (r_s1_a[k*LW +: LW]),
            .b    (r_s1_b[k*LW +: LW]),
            .sub  (r_s1_op == OP_PSUBS),
            .sat  (1'b1),
            .sum  (w_lane_sum[k*LW +: LW]),
            .cout (),
            .ovf  ()
        );
    end

`ifdef ALU_CARRY_FLAG_EN
    logic             r_s2_cf;
    logic             r_cf;
    logic             w_cf;
    logic             w_cin;
    logic [WIDTH:0]   w_addc_full;
    logic             w_addc_ovf;

    // An op leaving S2 this cycle commits its carry before ADDC, so forward it.
    assign w_cin       = (r_s2_valid && r_s2_fl) ? r_s2_cf : r_cf;
    assign w_addc_full = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {{WIDTH{1'b0}}, w_cin};
    assign w_addc_ovf  = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                         (w_addc_full[WIDTH-1] != r_s1_a[WIDTH-1]);
    assign cf          = r_cf;
`endif

    // Execute the op held in S1.
    always_comb begin
        w_res = {WIDTH{1'b0}};
        w_fl  = 1'b0;
        w_vf  = 1'b0;
`ifdef ALU_CARRY_FLAG_EN
        w_cf  = 1'b0;
`endif
        case (r_s1_op)
            OP_ADD, OP_SUB: begin
                w_res = w_full_sum;
                w_fl  = 1'b1;
                w_vf  = w_full_ovf;
`ifdef ALU_CARRY_FLAG_EN
                w_cf  = w_full_cout;
`endif
            end
            OP_PADDS, OP_PSUBS: w_res = w_lane_sum;
            OP_NAND:            w_res = ~(r_s1_a & r_s1_b);
            OP_XOR:             w_res = r_s1_a ^ r_s1_b;
            OP_PASSB:           w_res = r_s1_b;
`ifdef ALU_CARRY_FLAG_EN
            OP_ADDC: begin
                w_res = w_addc_full[WIDTH-1:0];
                w_fl  = 1'b1;
                w_vf  = w_addc_ovf;
                w_cf  = w_addc_full[WIDTH];
            end
`endif
            default:            w_res = {WIDTH{1'b0}};
        endcase
    end

    // S1: operand capture on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_a     <= {WIDTH{1'b0}};
            r_s1_b     <= {WIDTH{1'b0}};
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op <= op;
                r_s1_a  <= a;
                r_s1_b  <= b;
            end
        end
    end

    // S2: result register, frozen while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_fl    <= 1'b0;
            r_s2_vf    <= 1'b0;
            r_result   <= {WIDTH{1'b0}};
`ifdef ALU_CARRY_FLAG_EN
            r_s2_cf    <= 1'b0;
`endif
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (w_s1_adv) begin
                r_result <= w_res;
                r_s2_fl  <= w_fl;
                r_s2_vf  <= w_vf;
`ifdef ALU_CARRY_FLAG_EN
                r_s2_cf  <= w_cf;
`endif
            end
        end
    end

    // Flags commit on the output handshake from the transferred result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zf <= 1'b0;
            r_nf <= 1'b0;
            r_vf <= 1'b0;
`ifdef ALU_CARRY_FLAG_EN
            r_cf <= 1'b0;
`endif
        end else if (r_s2_valid && out_ready) begin
            r_zf <= (r_result == {WIDTH{1'b0}});
            if (r_s2_fl) begin
                r_nf <= r_result[WIDTH-1];
                r_vf <= r_s2_vf;
`ifdef ALU_CARRY_FLAG_EN
                r_cf <= r_s2_cf;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe_simd.sv
// Randomised bench for alu_pipe_simd against an in-order queue model, plus
// directed cases with literal expectations (ALU_CARRY_FLAG_EN aware).
module tb_alu_pipe_simd;

    localparam int W  = 16;
    localparam int LN = 2;
    localparam int LW = W / LN;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zf;
    logic         nf;
    logic         vf;
`ifdef ALU_CARRY_FLAG_EN
    logic         cf;
`endif

    always #5 clk = ~clk;

    alu_pipe_simd #(.WIDTH(W), .LANES(LN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zf        (zf),
        .nf        (nf),
`ifdef ALU_CARRY_FLAG_EN
        .cf        (cf),
`endif
        .vf        (vf)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } req_t;

    req_t q[$];
    int   n_err = 0;
    int   n_chk = 0;
    logic m_zf = 1'b0, m_nf = 1'b0, m_vf = 1'b0, m_cf = 1'b0;
    logic chk_en = 1'b0;
    logic rec_rst = 1'b1, rec_acc = 1'b0, rec_hs = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sext(input longint v, input int bits);
        if (((v >> (bits - 1)) & 64'd1) != 64'd0) return v - (longint'(1) << bits);
        else return v;
    endfunction

    // Reference semantics of one op; upd = op commits nf/vf(/cf).
    function automatic void model_exec(input req_t r, input logic cin, output logic [W-1:0] res,
                                       output logic upd, output logic v, output logic c);
        longint ua, ub, sa, sb, s, t, acc, lmask, la, lb, lhi, llo;
        ua = longint'(r.a);
        ub = longint'(r.b);
        sa = sext(ua, W);
        sb = sext(ub, W);
        s = 0; t = 0; upd = 1'b0; v = 1'b0; c = 1'b0; res = '0;
        case (r.op)
            3'd0: begin s = ua + ub; t = sa + sb; upd = 1'b1; end
            3'd1: begin s = ua + (((longint'(1) << W) - 1) ^ ub) + 1; t = sa - sb; upd = 1'b1; end
            3'd2, 3'd3: begin
                acc   = 0;
                lmask = (longint'(1) << LW) - 1;
                lhi   = (longint'(1) << (LW - 1)) - 1;
                llo   = -(longint'(1) << (LW - 1));
                for (int k = 0; k < LN; k++) begin
                    la = sext((ua >> (k * LW)) & lmask, LW);
                    lb = sext((ub >> (k * LW)) & lmask, LW);
                    t  = (r.op == 3'd2) ? la + lb : la - lb;
                    if (t > lhi) t = lhi;
                    if (t < llo) t = llo;
                    acc = acc | ((t & lmask) << (k * LW));
                end
                res = W'(acc);
            end
            3'd4: res = ~(r.a & r.b);
            3'd5: res = r.a ^ r.b;
            3'd6: res = r.b;
`ifdef ALU_CARRY_FLAG_EN
            3'd7: begin s = ua + ub + longint'(cin); t = sa + sb + longint'(cin); upd = 1'b1; end
`endif
            default: res = '0;
        endcase
        if (upd) begin
            res = W'(s);
            c   = ((s >> W) & 64'd1) != 64'd0;
            v   = (t > (longint'(1) << (W - 1)) - 1) || (t < -(longint'(1) << (W - 1)));
        end
    endfunction

    // Model update from handshakes seen before this edge.
    always @(posedge clk) begin : model_upd
        logic [W-1:0] r;
        logic u, v, c;
        if (rec_rst) begin
            q.delete();
            m_zf <= 1'b0; m_nf <= 1'b0; m_vf <= 1'b0; m_cf <= 1'b0;
        end else begin
            if (rec_hs && q.size() > 0) begin
                model_exec(q[0], m_cf, r, u, v, c);
                m_zf <= (r == '0);
                if (u) begin
                    m_nf <= r[W-1];
                    m_vf <= v;
                    m_cf <= c;
                end
                void'(q.pop_front());
            end
            if (rec_acc) q.push_back('{op: op, a: a, b: b});
        end
    end

    // Compare DUT against model on every falling edge.
    always @(negedge clk) begin : compare
        logic [W-1:0] r;
        logic u, v, c;
        rec_rst <= rst;
        rec_acc <= in_valid && in_ready;
        rec_hs  <= out_valid && out_ready;
        if (chk_en && !rst) begin
            check("zf", zf, m_zf);
            check("nf", nf, m_nf);
            check("vf", vf, m_vf);
`ifdef ALU_CARRY_FLAG_EN
            check("cf", cf, m_cf);
`endif
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_out: got out_valid=1 result=0x%0h, required no output", result);
                end else begin
                    model_exec(q[0], m_cf, r, u, v, c);
                    check("result", result, r);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op into an idle pipe with out_ready=1; checks latency and value.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp, input string name);
        op = o; a = x; b = y; in_valid = 1'b1;
        tick();
        check({name, "_lat1"}, out_valid, 1'b0);
        in_valid = 1'b0;
        tick();
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_res"}, result, exp);
        tick();
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [7];
        corners = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h7F80, 16'h807F};
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 6)];
        else return W'($urandom);
    endfunction

    initial begin : stim
        logic [W-1:0] got[$];
        logic acc;
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; a = '0; b = '0; out_ready = 1'b1;
        repeat (3) tick();
        check("in_ready_in_rst", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_flags", {zf, nf, vf}, 3'b000);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1'b1);
        chk_en = 1'b1;

        run_op(3'd0, 16'h7FFF, 16'h0001, 16'h8000, "add_ovf");
        check("add_ovf_flags", {zf, nf, vf}, 3'b011);
        run_op(3'd2, 16'h7F80, 16'h0180, 16'h7F80, "padds");
        check("padds_flags", {zf, nf, vf}, 3'b011);
        run_op(3'd3, 16'h8005, 16'h0107, 16'h80FE, "psubs");
        run_op(3'd1, 16'h1234, 16'h1234, 16'h0000, "sub_zero");
        check("sub_flags", {zf, nf, vf}, 3'b100);
        run_op(3'd4, 16'hFFFF, 16'hFFFF, 16'h0000, "nand");
        check("nand_flags", {zf, nf, vf}, 3'b100);
`ifdef ALU_CARRY_FLAG_EN
        run_op(3'd0, 16'hFFFF, 16'h0001, 16'h0000, "add_carry");
        check("add_carry_cf_zf", {cf, zf}, 2'b11);
        run_op(3'd7, 16'h0000, 16'h0000, 16'h0001, "addc");
        check("addc_cf_zf", {cf, zf}, 2'b00);
`else
        run_op(3'd7, 16'h1234, 16'h5678, 16'h0000, "rsvd");
`endif

        // Backpressure: six stalled cycles, three back-to-back ADDs.
        out_ready = 1'b0;
        op = 3'd0; a = 16'd1; b = 16'd1; in_valid = 1'b1;
        tick();
        a = 16'd2; b = 16'd2;
        tick();
        a = 16'd3; b = 16'd3;
        check("bp_in_ready_drop", in_ready, 1'b0);
        repeat (4) begin
            tick();
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_result", result, 16'h0002);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 12 && got.size() < 3; i++) begin
            #1;
            acc = in_valid && in_ready;
            if (out_valid) got.push_back(result);
            tick();
            if (acc) in_valid = 1'b0;
        end
        check("bp_count", got.size(), 3);
        check("bp_out0", (got.size() > 0) ? got[0] : 16'hDEAD, 16'h0002);
        check("bp_out1", (got.size() > 1) ? got[1] : 16'hDEAD, 16'h0004);
        check("bp_out2", (got.size() > 2) ? got[2] : 16'hDEAD, 16'h0006);
        in_valid = 1'b0;
        repeat (2) tick();

        // Reset with two ops in flight; flags are non-zero beforehand.
        run_op(3'd0, 16'h8000, 16'h8000, 16'h0000, "pre_rst");
        out_ready = 1'b0;
        op = 3'd5; a = 16'h00F0; b = 16'h0F00; in_valid = 1'b1;
        tick();
        a = 16'h1111;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", in_ready, 1'b0);
        tick();
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_result", result, 16'h0000);
        check("rst_mid_flags", {zf, nf, vf}, 3'b000);
        rst = 1'b0;
        #1;
        check("rst_mid_in_ready_after", in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (4) begin
            tick();
            check("no_stale", out_valid, 1'b0);
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            a         = pick();
            b         = pick();
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        tick();
        check("drain_empty", q.size(), 0);
        check("drain_out_valid", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
